// File: rtl/fx2_fifo_arbiter.sv
// rtl/fx2_fifo_arbiter.sv - FX2 slave-FIFO bus arbiter for command, reply and sample-data clients
module fx2_fifo_arbiter #(
    parameter logic [1:0] CMD_ADDR      = 2'b10,
    parameter logic [1:0] REPLY_ADDR    = 2'b01,
    parameter logic [1:0] DATA_ADDR     = 2'b00,
    parameter int         MAX_BURST     = 64,
    parameter int         FLUSH_TIMEOUT = 1024
) (
    input  logic       ifclk,
    input  logic       reset,
    output logic [1:0] fifoadr,
    output logic       sloe,
    output logic       slrd,
    output logic       slwr,
    output logic       pktend,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    input  logic       flag_empty,
    input  logic       flag_full,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic [7:0] reply_data,
    input  logic       reply_valid,
    input  logic       reply_last,
    output logic       reply_ready,
    input  logic [7:0] data_data,
    input  logic       data_valid,
    output logic       data_ready
);

    localparam int FW = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEL, READ, WRITE_R, WRITE_D, PKTEND} state_t;

    state_t        state, next_state, sel_target, arb_target;
    logic [1:0]    arb_addr;
    logic          arb_req;
    logic [7:0]    burst;
    logic          burst_done;
    logic [FW-1:0] flush_cnt;
    logic          flush_due;
    logic          dirty;
    logic          cmd_known_empty;
    logic [3:0]    empty_idle_cnt;

    assign burst_done = (burst == 8'(MAX_BURST));
    assign flush_due  = dirty && (flush_cnt == FW'(FLUSH_TIMEOUT));

    always_comb begin
        arb_req    = 1'b1;
        arb_target = IDLE;
        arb_addr   = CMD_ADDR;
        if (reply_valid) begin
            arb_target = WRITE_R;
            arb_addr   = REPLY_ADDR;
        end else if (flush_due) begin
            arb_target = PKTEND;
            arb_addr   = DATA_ADDR;
        end else if (!cmd_known_empty) begin
            arb_target = READ;
            arb_addr   = CMD_ADDR;
        end else if (data_valid) begin
            arb_target = WRITE_D;
            arb_addr   = DATA_ADDR;
        end else begin
            arb_req    = 1'b0;
        end
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arb_req) next_state = SEL;
            SEL:     next_state = sel_target;
            READ:    if (flag_empty || burst_done || reply_valid) next_state = IDLE;
            WRITE_R: begin
                if (slwr && reply_last)           next_state = PKTEND;
                else if (flag_full || burst_done) next_state = IDLE;
            end
            WRITE_D: if (!data_valid || flag_full || burst_done || reply_valid) next_state = IDLE;
            PKTEND:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are suppressed on the exit cycle so a grant never exceeds MAX_BURST
    always_comb begin
        slrd        = 1'b0;
        reply_ready = 1'b0;
        data_ready  = 1'b0;
        fd_out      = data_data;
        if (state == WRITE_R) fd_out = reply_data;
        if (!reset) begin
            slrd        = (state == READ) && !flag_empty && (!cmd_valid || cmd_ready)
                          && !burst_done && !reply_valid;
            reply_ready = (state == WRITE_R) && reply_valid && !flag_full && !burst_done;
            data_ready  = (state == WRITE_D) && data_valid && !flag_full && !burst_done
                          && !reply_valid;
        end
        slwr = reply_ready || data_ready;
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            fifoadr         <= CMD_ADDR;
            sel_target      <= IDLE;
            sloe            <= 1'b0;
            fd_oe           <= 1'b0;
            pktend          <= 1'b0;
            cmd_data        <= 8'h00;
            cmd_valid       <= 1'b0;
            burst           <= 8'd0;
            flush_cnt       <= '0;
            dirty           <= 1'b0;
            cmd_known_empty <= 1'b0;
            empty_idle_cnt  <= 4'd0;
        end else begin
            if (state == IDLE && arb_req) begin
                fifoadr    <= arb_addr;
                sel_target <= arb_target;
            end
            sloe   <= (next_state == READ);
            fd_oe  <= (next_state == WRITE_R) || (next_state == WRITE_D);
            pktend <= (next_state == PKTEND);

            if (next_state == SEL) begin
                burst <= 8'd0;
            end else if (slrd || slwr) begin
                burst <= burst + 8'd1;
            end

            if (slrd) begin
                cmd_data  <= fd_in;
                cmd_valid <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            if (data_ready) begin
                dirty     <= 1'b1;
                flush_cnt <= '0;
            end else if (state == PKTEND && fifoadr == DATA_ADDR) begin
                dirty     <= 1'b0;
                flush_cnt <= '0;
            end else if (dirty && state != WRITE_D && !flush_due) begin
                flush_cnt <= flush_cnt + 1'b1;
            end

            // Known-empty mark keeps an idle command endpoint from hogging arbitration
            if (state == READ && next_state == IDLE && flag_empty) begin
                cmd_known_empty <= 1'b1;
                empty_idle_cnt  <= 4'd0;
            end else if (state == IDLE && arb_req && arb_target != READ) begin
                cmd_known_empty <= 1'b0;
            end else if (cmd_known_empty && state == IDLE) begin
                if (empty_idle_cnt == 4'd15) cmd_known_empty <= 1'b0;
                empty_idle_cnt <= empty_idle_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// tb/tb_fx2_fifo_arbiter.sv - directed self-checking bench for fx2_fifo_arbiter
module tb_fx2_fifo_arbiter;

    logic       ifclk = 1'b0;
    logic       reset;
    logic [1:0] fifoadr;
    logic       sloe, slrd, slwr, pktend, fd_oe;
    logic [7:0] fd_in, fd_out;
    logic       flag_empty, flag_full;
    logic [7:0] cmd_data;
    logic       cmd_valid, cmd_ready;
    logic [7:0] reply_data;
    logic       reply_valid, reply_last, reply_ready;
    logic [7:0] data_data;
    logic       data_valid, data_ready;

    logic [7:0] cmd_mem [0:15];
    logic [7:0] rep_mem [0:15];
    logic       rep_lst [0:15];
    int cmd_rd = 0, cmd_wr = 0, rep_rd = 0, rep_wr = 0, dat_rd = 0, dat_wr = 0;

    int cyc = 0;
    logic [7:0] cmd_log [0:15];
    int cmd_n = 0;
    logic [7:0] rep_log [0:15];
    int rep_n = 0;
    int data_total = 0, data_bad = 0, last_dwr_cyc = 0;
    int run_len [0:7];
    int run_n = 0;
    logic prev_dwr = 1'b0;
    int pk_n = 0, pk_cyc = 0;
    logic [1:0] pk_addr = 2'b11;

    int checks = 0, errors = 0;

    always #5 ifclk = ~ifclk;

    fx2_fifo_arbiter dut (
        .ifclk(ifclk), .reset(reset), .fifoadr(fifoadr), .sloe(sloe), .slrd(slrd),
        .slwr(slwr), .pktend(pktend), .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
        .flag_empty(flag_empty), .flag_full(flag_full), .cmd_data(cmd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .reply_data(reply_data),
        .reply_valid(reply_valid), .reply_last(reply_last), .reply_ready(reply_ready),
        .data_data(data_data), .data_valid(data_valid), .data_ready(data_ready)
    );

    // FX2 endpoint and client source models
    assign fd_in       = cmd_mem[cmd_rd[3:0]];
    assign flag_empty  = (fifoadr == 2'b10) ? (cmd_rd == cmd_wr) : 1'b0;
    assign reply_valid = (rep_rd < rep_wr);
    assign reply_data  = rep_mem[rep_rd[3:0]];
    assign reply_last  = rep_lst[rep_rd[3:0]];
    assign data_valid  = (dat_rd < dat_wr);
    assign data_data   = 8'(dat_rd) ^ 8'h5A;

    always @(posedge ifclk) begin
        cyc <= cyc + 1;
        if (slrd) cmd_rd <= cmd_rd + 1;
        if (reply_ready) rep_rd <= rep_rd + 1;
        if (data_ready) dat_rd <= dat_rd + 1;
        if (cmd_valid && cmd_ready && cmd_n < 16) begin
            cmd_log[cmd_n] <= cmd_data;
            cmd_n <= cmd_n + 1;
        end
        if (slwr && fifoadr == 2'b01 && rep_n < 16) begin
            rep_log[rep_n] <= fd_out;
            rep_n <= rep_n + 1;
        end
        if (slwr && fifoadr == 2'b00) begin
            data_total   <= data_total + 1;
            last_dwr_cyc <= cyc;
            if (fd_out !== (8'(dat_rd) ^ 8'h5A)) data_bad <= data_bad + 1;
            if (!prev_dwr && run_n < 8) begin
                run_len[run_n] <= 1;
                run_n <= run_n + 1;
            end else if (prev_dwr && run_n > 0) begin
                run_len[run_n-1] <= run_len[run_n-1] + 1;
            end
        end
        prev_dwr <= slwr && (fifoadr == 2'b00);
        if (pktend) begin
            pk_n    <= pk_n + 1;
            pk_addr <= fifoadr;
            pk_cyc  <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_flush(input string tag);
        int n0;
        int guard;
        int delta;
        n0 = pk_n;
        guard = 0;
        while (pk_n == n0 && guard < 1200) begin
            @(negedge ifclk);
            guard++;
        end
        check({tag, "_seen"}, pk_n, n0 + 1);
        check({tag, "_addr"}, pk_addr, 2'b00);
        delta = pk_cyc - last_dwr_cyc;
        if (!(delta >= 1026 && delta <= 1032))
            $display("flush delta was %0d cycles", delta);
        check({tag, "_delay_in_window"}, (delta >= 1026 && delta <= 1032), 1);
        repeat (150) @(negedge ifclk);
        check({tag, "_once"}, pk_n, n0 + 1);
    endtask

    initial begin
        int guard;
        int n0;
        for (int i = 0; i < 16; i++) begin
            cmd_mem[i] = 8'h00;
            rep_mem[i] = 8'h00;
            rep_lst[i] = 1'b0;
        end
        cmd_mem[0] = 8'h01; cmd_mem[1] = 8'h02; cmd_mem[2] = 8'h03;
        reset = 1'b1;
        cmd_ready = 1'b1;
        flag_full = 1'b0;
        cmd_wr = 3;
        repeat (3) @(negedge ifclk);

        check("rst_fifoadr", fifoadr, 2'b10);
        check("rst_sloe", sloe, 0);
        check("rst_fd_oe", fd_oe, 0);
        check("rst_pktend", pktend, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 8'h00);
        check("rst_slrd", slrd, 0);

        // Command read: 3 bytes, strobe 2 cycles after IDLE
        reset = 1'b0;
        @(negedge ifclk);
        check("sel_fifoadr", fifoadr, 2'b10);
        check("sel_sloe", sloe, 0);
        check("sel_slrd", slrd, 0);
        @(negedge ifclk);
        check("rd1_sloe", sloe, 1);
        check("rd1_slrd", slrd, 1);
        @(negedge ifclk);
        check("rd2_slrd", slrd, 1);
        check("rd2_cmd", {cmd_valid, cmd_data}, 9'h101);
        @(negedge ifclk);
        check("rd3_slrd", slrd, 1);
        check("rd3_cmd", {cmd_valid, cmd_data}, 9'h102);
        @(negedge ifclk);
        check("rd_empty_slrd", slrd, 0);
        check("rd_empty_cmd", {cmd_valid, cmd_data}, 9'h103);
        @(negedge ifclk);
        check("rd_exit_sloe", sloe, 0);
        check("rd_exit_cmd_valid", cmd_valid, 0);
        check("cmd_log_n", cmd_n, 3);
        check("cmd_log", {cmd_log[0], cmd_log[1], cmd_log[2]}, 24'h010203);

        // Reply packet AA,BB with turnaround gap and pktend
        rep_mem[0] = 8'hAA; rep_mem[1] = 8'hBB; rep_lst[1] = 1'b1;
        rep_wr = 2;
        @(negedge ifclk);
        check("rsel_fifoadr", fifoadr, 2'b01);
        check("rsel_gap", {sloe, fd_oe, slwr}, 3'b000);
        @(negedge ifclk);
        check("rw1", {fd_oe, slwr, reply_ready, fd_out}, 11'h7AA);
        @(negedge ifclk);
        check("rw2", {fd_oe, slwr, reply_ready, fd_out}, 11'h7BB);
        @(negedge ifclk);
        check("rpk", {pktend, slwr, fd_oe}, 3'b100);
        @(negedge ifclk);
        check("rpk_done", pktend, 0);
        check("rep_log", {rep_n[7:0], rep_log[0], rep_log[1]}, 24'h02AABB);
        check("rep_pk_addr", {pk_n[7:0], pk_addr}, 10'h005);

        // 200-byte stream split into 64,64,64,8
        n0 = pk_n;
        dat_wr = 200;
        guard = 0;
        while (data_total < 200 && guard < 1000) begin
            @(negedge ifclk);
            guard++;
        end
        check("stream_total", data_total, 200);
        check("stream_runs", run_n, 4);
        check("stream_len0", run_len[0], 64);
        check("stream_len1", run_len[1], 64);
        check("stream_len2", run_len[2], 64);
        check("stream_len3", run_len[3], 8);
        check("stream_no_pktend", pk_n, n0);
        wait_flush("stream_flush");

        // 10 bytes then idle -> single timeout flush
        dat_wr = dat_wr + 10;
        guard = 0;
        while (data_total < 210 && guard < 200) begin
            @(negedge ifclk);
            guard++;
        end
        check("short_total", data_total, 210);
        check("short_run", run_len[4], 10);
        wait_flush("short_flush");
        check("data_bytes_bad", data_bad, 0);

        // Reply preempts a stalled read burst
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) cmd_mem[3+i] = 8'h11 + 8'(i);
        cmd_wr = 8;
        guard = 0;
        while (!(cmd_valid && sloe) && guard < 60) begin
            @(negedge ifclk);
            guard++;
        end
        check("stall_read_started", {cmd_valid, sloe, cmd_data}, 10'h311);
        n0 = pk_n;
        rep_mem[2] = 8'hCC; rep_lst[2] = 1'b1;
        rep_wr = 3;
        guard = 0;
        while (pk_n == n0 && guard < 30) begin
            @(negedge ifclk);
            guard++;
        end
        check("preempt_pktend", {pk_n == n0 + 1, pk_addr}, 3'b101);
        check("preempt_reply", {rep_n[7:0], rep_log[2]}, 16'h03CC);
        check("preempt_reads_held", cmd_rd, 4);
        cmd_ready = 1'b1;
        guard = 0;
        while (cmd_n < 8 && guard < 100) begin
            @(negedge ifclk);
            guard++;
        end
        check("resume_n", cmd_n, 8);
        check("resume_bytes", {cmd_log[3], cmd_log[4], cmd_log[5], cmd_log[6], cmd_log[7]},
              40'h1112131415);

        // Reset in the middle of a data burst
        dat_wr = dat_rd + 50;
        guard = 0;
        while (!(slwr && fifoadr == 2'b00) && guard < 100) begin
            @(negedge ifclk);
            guard++;
        end
        check("mid_burst_writing", {slwr, fifoadr}, 3'b100);
        n0 = pk_n;
        reset = 1'b1;
        #1;
        check("rst_mid_slwr", {slwr, data_ready}, 2'b00);
        @(negedge ifclk);
        dat_wr = dat_rd;
        check("rst_mid_fifoadr", fifoadr, 2'b10);
        check("rst_mid_outs", {sloe, fd_oe, pktend, cmd_valid, slrd, slwr}, 6'b000000);
        check("rst_mid_cmd_data", cmd_data, 8'h00);
        reset = 1'b0;
        repeat (40) @(negedge ifclk);
        check("rst_mid_no_pktend", pk_n, n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx2_fifo_arbiter.md
Name: fx2_fifo_arbiter

Overview:
Sequences the shared FX2 slave-FIFO bus (fifoadr, sloe, slrd, slwr, pktend, 8-bit data) between three FPGA-side clients:
- a command reader draining the host OUT endpoint;
- a reply writer (high priority, packetised);
- a sample-data streamer with idle-timeout flush.

It sits between the timetag/command logic and the FX2 pins, and owns bus turnaround, endpoint selection and burst limits.

Parameters:
CMD_ADDR, 2'b10, fifoadr of the host->device command endpoint
REPLY_ADDR, 2'b01, fifoadr of the reply IN endpoint
DATA_ADDR, 2'b00, fifoadr of the sample-data IN endpoint
MAX_BURST, 64, max bytes per grant before re-arbitration (1..255)
FLUSH_TIMEOUT, 1024, idle cycles before a partial data packet is committed with pktend (>=2)

Ports:
ifclk in 1 bus clock; all logic on posedge
reset in 1 synchronous, active-high reset
fifoadr out 2 endpoint select
sloe out 1 FX2 output enable (FX2 drives fd_in)
slrd out 1 read strobe, active-high
slwr out 1 write strobe, active-high
pktend out 1 commit-packet strobe, active-high
fd_in in 8 data from FX2
fd_out out 8 data to FX2
fd_oe out 1 FPGA drives data bus
flag_empty in 1 selected endpoint empty
flag_full in 1 selected endpoint full
cmd_data out 8 command byte
cmd_valid out 1 cmd_data valid
cmd_ready in 1 consumer accepts
reply_data in 8 reply byte
reply_valid in 1 reply byte offered
reply_last in 1 marks last byte of reply packet
reply_ready out 1 reply byte accepted
data_data in 8 sample byte
data_valid in 1 sample byte offered
data_ready out 1 sample byte accepted

Behaviour:
- Clock and reset: one clock, ifclk. reset is synchronous and active-high. Reset values:
  - state=IDLE, fifoadr=CMD_ADDR;
  - sloe, fd_oe, cmd_valid, pktend = 0; cmd_data=8'h00;
  - burst and flush counters = 0; dirty=0.
- Strobes: slrd, slwr, reply_ready and data_ready are combinational from state and inputs, and are forced 0 whenever reset=1. fifoadr, sloe, fd_oe and pktend are registered.
- States: IDLE, SEL, READ, WRITE_R, WRITE_D, PKTEND.
- IDLE arbitration, fixed priority:
  1. reply_valid -> REPLY_ADDR
  2. flush_due -> DATA_ADDR with flush flag
  3. cmd endpoint not known-empty -> CMD_ADDR
  4. data_valid -> DATA_ADDR
  Nothing pending: stay IDLE.
- SEL: exactly 1 cycle. fifoadr loaded, sloe=fd_oe=0 (bus turnaround); flags are ignored. Next state is READ, WRITE_R, WRITE_D, or PKTEND (flush).
- READ:
  - sloe=1.
  - slrd = !flag_empty && (!cmd_valid || cmd_ready).
  - On a slrd edge: cmd_data<=fd_in, cmd_valid<=1, burst++. cmd_valid clears when consumed with no new read.
  - Exit to IDLE when flag_empty, burst==MAX_BURST, or reply_valid (this prevents command/reply deadlock).
  - On exit via flag_empty, the cmd endpoint is marked known-empty. The mark is retried only after another client has been served or 16 idle cycles have passed.
- WRITE_R / WRITE_D:
  - fd_oe=1; fd_out = selected source data.
  - slwr = src_valid && !flag_full; src_ready=slwr.
  - Each write does burst++.
  - WRITE_D: sets dirty=1 and clears the flush counter on each write. Exits on !data_valid, flag_full, burst==MAX_BURST, or reply_valid.
  - WRITE_R: on a write with reply_last=1 -> PKTEND. Exits to IDLE on flag_full or burst==MAX_BURST (packet continues at next grant).
- PKTEND: pktend=1 for exactly 1 cycle; no slwr in the same cycle. If fifoadr==DATA_ADDR, dirty<=0. Then IDLE.
- Flush counter: increments each cycle while dirty && not in WRITE_D, saturating at FLUSH_TIMEOUT. flush_due = (count==FLUSH_TIMEOUT).
- burst is cleared on entry to SEL.
- Latency: request in IDLE -> first strobe 2 cycles later (IDLE, SEL, strobe).
- Simultaneous events:
  - reply_valid and flush_due together -> reply served first.
  - Reset mid-burst -> strobes drop in that cycle; no pktend is issued; partial packets are abandoned.

Test Plan:
- Cmd endpoint holds 3 bytes 01 02 03, cmd_ready=1 -> slrd high 3 cycles starting 2 cycles after IDLE; cmd_data sequence 01,02,03; return to IDLE when flag_empty.
- reply bytes AA,BB with reply_last on BB -> fifoadr=01, two slwr cycles, then pktend for 1 cycle with no slwr; the sloe=fd_oe=0 gap holds for 1 cycle.
- 200 data bytes continuous, MAX_BURST=64 -> four grants of 64,64,64,8; re-arbitration between grants; no pktend.
- 10 data bytes then idle, FLUSH_TIMEOUT=1024 -> pktend on DATA_ADDR exactly once, ~1026 cycles after the last write; dirty cleared.
- reply_valid raised mid read burst with cmd_ready=0 -> READ exits, reply written, reads then resume; no deadlock.
- reset asserted during WRITE_D -> slwr=0 in the same cycle; next cycle fifoadr=10 and all outputs at reset values.
